// File: rtl/mux6_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux6_pkg
//  Purpose  : Shared constants, FSM state type and index helper for the
//             six-way round-robin output scheduler.
//  Revision : 1.0
// ============================================================================
package mux6_pkg;

    localparam int NREQ  = 6;
    localparam int SEL_W = 3;
    localparam int DW    = 4;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NREQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // (sel + 1) mod 6 without a divider; indices 6/7 never occur
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] sel);
        return (sel >= LAST_IDX) ? '0 : sel + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick6.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick6
//  Purpose  : Combinational rotating-priority picker; returns the first set
//             request scanning ptr, ptr+1, ... mod 6.
//  Revision : 1.0
// ============================================================================
module rr_pick6
    import mux6_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux6_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mux6_rr_sched
//  Purpose  : Round-robin burst scheduler sharing one registered 4-bit output
//             channel among six valid/ready requesters.
//  Revision : 1.0
// ============================================================================
module mux6_rr_sched
    import mux6_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_last,
    input  logic [DW-1:0]    data0,
    input  logic [DW-1:0]    data1,
    input  logic [DW-1:0]    data2,
    input  logic [DW-1:0]    data3,
    input  logic [DW-1:0]    data4,
    input  logic [DW-1:0]    data5,
    output logic [NREQ-1:0]  req_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    sched_state_t     state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic [DW-1:0]    sel_data;
    logic [3:0]       beat_inc;
    logic             granted;
    logic             can_accept;
    logic             valid_sel;
    logic             last_sel;
    logic             xfer;
    logic             rel_grant;

    rr_pick6 u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_data = '0;
        case (sel_q)
            3'd0:    sel_data = data0;
            3'd1:    sel_data = data1;
            3'd2:    sel_data = data2;
            3'd3:    sel_data = data3;
            3'd4:    sel_data = data4;
            3'd5:    sel_data = data5;
            default: sel_data = '0;
        endcase
    end

    assign granted    = (state_q == GRANT);
    assign can_accept = !out_valid_q || out_ready;
    assign valid_sel  = req_valid[sel_q];
    assign last_sel   = req_last[sel_q];
    assign xfer       = granted && valid_sel && can_accept;
    assign beat_inc   = beat_cnt_q + 4'd1;

    // A stalled beat (valid, not ready) holds the grant; only an empty cycle
    // or a completed terminal beat gives it up.
    assign rel_grant  = granted && (xfer ? (last_sel || (beat_inc == BURST_LIMIT))
                                         : !valid_sel);

    always_comb begin
        req_ready = '0;
        if (granted && can_accept) begin
            req_ready[sel_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d      = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    beat_cnt_d  = beat_inc;
                end
                if (rel_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(sel_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = granted;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: doc/mux6_rr_sched.md
# mux6_rr_sched

Round-robin scheduler that shares one 4-bit output channel among six valid/ready requesters. It arbitrates between the requesters and drives the 3-bit select of the 6:1 data multiplexer. It forwards the granted requester's beats through a one-entry output register. It sits between the six data producers and the single downstream consumer, and grants in bursts terminated by `req_last` or a beat limit.

## Interface
- `NREQ`, 6: number of requesters; fixed at 6 for this revision.
- `SEL_W`, 3: select width.
- `DW`, 4: data width.
- `MAX_BURST`, 4: maximum beats per grant before forced rotation; legal range 1..15.

- `clk` in 1: single clock; all state changes on its rising edge.
- `areset_n` in 1: reset is asynchronous and active-low.
- `req_valid` in 6: per-requester beat valid.
- `req_last` in 6: per-requester end-of-burst flag; qualified by the matching valid.
- `data0`..`data5` in 4 each: requester data.
- `req_ready` out 6: one-hot or zero; only `req_ready[sel]` can be 1.
- `sel` out 3: current grant index 0..5; values 6 and 7 are never driven.
- `out_valid` out 1: output beat valid.
- `out_data` out 4: output beat data; 0 whenever `out_valid`=0.
- `out_ready` in 1: downstream accept.
- `busy` out 1: 1 while in GRANT.

## Operation
- FSM has two states, IDLE and GRANT.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit scanning `rr_ptr`, `rr_ptr`+1, … mod 6.
  - Register the pick into `sel`, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` is set, stay in IDLE; `sel` holds its last value.
- **GRANT**
  - `req_ready[sel]` = (!`out_valid` || `out_ready`); all other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[sel]` && `req_ready[sel]`. On a transfer the output register loads the selected data, `out_valid` is set, and `beat_cnt` increments.
  - Release to IDLE when any of these holds:
    - a transfer with `req_last[sel]`=1;
    - a transfer that makes `beat_cnt` equal `MAX_BURST`;
    - a cycle with `req_valid[sel]`=0.
  - On release, `rr_ptr` ← (`sel`+1) mod 6, so the released requester has the lowest priority next round.
  - Stalled cycles (valid=1, ready=0) never release.
- **Output register**
  - When `out_valid` && `out_ready` with no new transfer: `out_valid` ← 0 and `out_data` ← 0.
  - A simultaneous drain and load takes the new beat; no bubble.
- **Reset values** (asynchronous on `areset_n`=0)
  - Registers: state=IDLE, `sel`=0, `rr_ptr`=0, `beat_cnt`=0, `out_valid`=0, `out_data`=0.
  - Derived outputs: `req_ready`=0, `busy`=0.
  - Reset asserted mid-burst discards the output beat; no partial state survives.
- `beat_cnt` is 4 bits and is compared with `==`. It never wraps because release occurs at `MAX_BURST`.

## Timing
- `req_valid` rising in IDLE at cycle 0 → `sel`/`busy` valid at cycle 1 → `req_ready` combinationally high in cycle 1 if the output can accept → `out_valid` at cycle 2.
- Minimum latency is 2 cycles from valid to output.
- Steady burst throughput is 1 beat/cycle while `out_ready`=1.
- Release costs exactly one IDLE arbitration cycle, during which all `req_ready`=0.
- `req_ready` depends combinationally on `out_ready`. No input-to-output combinational path exists on data.

## Structure
- Package `mux6_pkg`:
  - constants `NREQ`, `SEL_W`, `DW`;
  - enum `sched_state_t` {IDLE, GRANT};
  - function `wrap_inc(sel)` returning (`sel`+1) mod 6.
- Sub-module `rr_pick6`: combinational rotating priority picker.
  - Inputs: `req[5:0]`, `ptr[2:0]`.
  - Outputs: `idx[2:0]`, `any`.
  - Instantiated once in the IDLE decision path.
- Data select is a case on `sel` over `data0`..`data5`, default 0, feeding the output register.

## Test plan
- Reset during an active burst (`out_valid`=1, state GRANT) → all outputs return to reset values immediately. After release the first grant goes to the lowest-index valid requester.
- Requesters 1 and 4 both valid continuously, single-beat bursts (`req_last`=1), `out_ready`=1 → `sel` sequence 1,4,1,4, with one idle cycle between grants.
- Requester 2 sends 7 beats with `req_last` only on beat 7, `MAX_BURST`=4, requester 3 also valid → beats 0..3 of requester 2, then requester 3, then requester 2 resumes with beats 4..6.
- `out_ready` held 0 for 3 cycles mid-burst → `req_ready[sel]`=0, no beat lost or duplicated, `out_data` is stable, and the grant is held.
- `data5`=4'hA granted, `out_ready`=1 → `out_data`=4'hA for one cycle, then 0 with `out_valid`=0 when the requester deasserts valid. The grant releases and `rr_ptr` becomes 0.
- All six requesters valid with single beats, starting from reset → grant order 0,1,2,3,4,5,0. `sel` never takes values 6 or 7.
